pipe_hazard_ctrl: RTL

- Pipeline controller for the fetch/decode/execute front end.
- Detects load-use hazards, instruction-memory and data-memory stalls, branch/jump redirects and exceptions.
- Sequences the stall, flush and bubble controls that drive the IF/ID register, the PC and the ID/EX register.
- Generates per-operand forwarding selects for the decode-stage operand muxes, replacing the single shared forward select.

---
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Front-end pipeline controller: hazard detection, stall/flush/bubble sequencing and
// per-operand forwarding selects. Define PIPE_HAZARD_PERF_EN to add performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES     = 1,
  parameter int unsigned EXC_DRAIN_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_waddr,
  input  logic       ex_we,
  input  logic       ex_load,
  input  logic [4:0] mem_waddr,
  input  logic       mem_we,
  input  logic [4:0] wb_waddr,
  input  logic       wb_we,
  input  logic       if_stall,
  input  logic       mem_stall,
  input  logic       take_branch,
  input  logic       jump_op,
  input  logic       exc_req,
  output logic       pc_hold,
  output logic       ifid_hold,
  output logic       ifid_flush,
  output logic       id_ready,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic [2:0] ctrl_state
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] perf_ld_stalls,
  output logic [31:0] perf_mem_stalls,
  output logic [31:0] perf_flushes
`endif
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_LDSTALL = 3'd1,
    ST_MWAIT   = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_EXC     = 3'd4
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] EXC_INIT   = 3'(EXC_DRAIN_CYCLES - 1);

  state_t     state_q, state_d;
  state_t     resume_q, resume_d;
  state_t     eff_state;
  logic [2:0] cnt_q, cnt_d;
  logic       load_use;
  logic       redirect;

  // While waiting on data memory, the release cycle behaves as the saved state.
  assign eff_state = (state_q == ST_MWAIT) ? resume_q : state_q;
  assign redirect  = take_branch | jump_op;
  assign load_use  = ex_load & ex_we & (ex_waddr != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_waddr)) |
                      (id_use_rs2 & (id_rs2 == ex_waddr)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_EXC;
      cnt_q    <= EXC_INIT;
      resume_q <= ST_RUN;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      resume_q <= resume_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    resume_d = resume_q;
    if (exc_req) begin
      state_d = ST_EXC;
      cnt_d   = EXC_INIT;
    end else if (eff_state == ST_EXC) begin
      if (cnt_q == 3'd0) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_EXC;
        cnt_d   = cnt_q - 3'd1;
      end
    end else if (mem_stall) begin
      state_d  = ST_MWAIT;
      resume_d = eff_state;
    end else if (if_stall) begin
      state_d = eff_state;
    end else if (eff_state == ST_FLUSH) begin
      // The redirect cycle itself was the first flush, so FLUSH lasts cnt cycles.
      cnt_d   = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
      state_d = (cnt_q <= 3'd1) ? ST_RUN : ST_FLUSH;
    end else if (redirect) begin
      cnt_d   = FLUSH_INIT;
      state_d = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
    end else if (load_use) begin
      state_d = ST_LDSTALL;
    end else begin
      state_d = ST_RUN;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (mem_we && mem_waddr == rs && rs != 5'd0)     return 2'b01;
    else if (wb_we && wb_waddr == rs && rs != 5'd0)  return 2'b10;
    else                                             return 2'b00;
  endfunction

  always_comb begin
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    id_ready   = 1'b1;
    fwd_a_sel  = fwd_sel(id_rs1);
    fwd_b_sel  = fwd_sel(id_rs2);
    ctrl_state = state_q;
    if (rst_i) begin
      ifid_flush = 1'b1;
      id_ready   = 1'b0;
      fwd_a_sel  = 2'b00;
      fwd_b_sel  = 2'b00;
      ctrl_state = ST_EXC;
    end else if (exc_req || eff_state == ST_EXC) begin
      ifid_flush = 1'b1;
      id_ready   = 1'b0;
    end else if (mem_stall) begin
      pc_hold   = 1'b1;
      ifid_hold = 1'b1;
      id_ready  = 1'b0;
    end else if (if_stall) begin
      pc_hold    = 1'b1;
      ifid_flush = 1'b1;
    end else if (eff_state == ST_FLUSH) begin
      ifid_flush = 1'b1;
    end else if (redirect) begin
      ifid_flush = 1'b1;
    end else if (load_use) begin
      pc_hold   = 1'b1;
      ifid_hold = 1'b1;
      id_ready  = 1'b0;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_ld_stalls  <= 32'd0;
      perf_mem_stalls <= 32'd0;
      perf_flushes    <= 32'd0;
    end else begin
      if (state_q == ST_LDSTALL && perf_ld_stalls != 32'hFFFF_FFFF)
        perf_ld_stalls <= perf_ld_stalls + 32'd1;
      if (mem_stall && perf_mem_stalls != 32'hFFFF_FFFF)
        perf_mem_stalls <= perf_mem_stalls + 32'd1;
      if (ifid_flush && ctrl_state != ST_EXC && perf_flushes != 32'hFFFF_FFFF)
        perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule
